btb_update_ctrl: RTL and testbench

//  Write-port controller for branch_target_buffer. Sits between the execute-stage

---
 rtl/btb_pkg.sv | 18 +
 rtl/btb_update_ctrl_if.sv | 30 +++
 rtl/btb_upd_fifo.sv | 67 ++++++
 rtl/btb_update_ctrl.sv | 114 +++++++++++
 tb/tb_btb_update_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/btb_pkg.sv
// Shared types and defaults for the BTB write-port controller.
package btb_pkg;

    localparam int BTB_INDEX_BITS = 10;
    localparam int BTB_INDEX_LSB  = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } btb_upd_t;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Resolved-branch update channel and BTB write-port bundle.
// upd_*: valid/ready; a transfer happens on a rising edge where upd_valid & upd_ready,
// the producer holds fields stable while valid, and ready never depends on valid.
interface btb_update_ctrl_if;

    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;

    logic        btb_write;
    logic        btb_invalidate;
    logic        btb_branch_taken;
    logic [31:0] btb_new_pc;
    logic [31:0] btb_data;

    modport master (
        output upd_valid, upd_pc, upd_target, upd_taken,
        input  upd_ready,
        input  btb_write, btb_invalidate, btb_branch_taken, btb_new_pc, btb_data
    );

    modport slave (
        input  upd_valid, upd_pc, upd_target, upd_taken,
        output upd_ready,
        output btb_write, btb_invalidate, btb_branch_taken, btb_new_pc, btb_data
    );

endinterface

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO of pending BTB updates; clear has priority over push and pop.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  btb_upd_t      wdata,
    output btb_upd_t      rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    btb_upd_t      mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push & ~full & ~clear;
    assign pop_ok  = pop & ~empty & ~clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is the natural overflow.
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-port controller: queues resolved-branch updates and runs the
// invalidate walk after reset and on flush, issuing at most one write per cycle.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter  int DEPTH      = 4,
    parameter  int INDEX_BITS = BTB_INDEX_BITS,
    parameter  int INDEX_LSB  = BTB_INDEX_LSB,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic               btbc_clk,
    input  logic               btbc_reset,
    btb_update_ctrl_if.slave   bus,
    input  logic               flush_req,
    output logic               flush_busy,
    output logic [CW-1:0]      fifo_count,
    output ctrl_state_e        dbg_state
);

    ctrl_state_e           state_q, state_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d;
    logic                  write_q, write_d;
    logic                  inv_q, inv_d;
    logic                  taken_q, taken_d;
    logic [31:0]           pc_q, pc_d;
    logic [31:0]           data_q, data_d;

    btb_upd_t fifo_wdata;
    btb_upd_t fifo_rdata;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_pop;

    assign fifo_wdata = '{pc: bus.upd_pc, target: bus.upd_target, taken: bus.upd_taken};
    assign fifo_pop   = (state_q == RUN) & ~fifo_empty & ~flush_req;

    btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (btbc_clk),
        .rst_n (btbc_reset),
        .push  (bus.upd_valid),
        .pop   (fifo_pop),
        .clear (flush_req),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        write_d = 1'b0;
        inv_d   = 1'b0;
        taken_d = taken_q;
        pc_d    = pc_q;
        data_d  = data_q;
        if (flush_req) begin
            state_d = FLUSH;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                FLUSH: begin
                    write_d = 1'b1;
                    inv_d   = 1'b1;
                    taken_d = 1'b0;
                    data_d  = '0;
                    pc_d    = 32'(idx_q) << INDEX_LSB;
                    idx_d   = idx_q + INDEX_BITS'(1);
                    if (idx_q == '1) state_d = RUN;
                end
                RUN: begin
                    if (!fifo_empty) begin
                        write_d = 1'b1;
                        taken_d = fifo_rdata.taken;
                        pc_d    = fifo_rdata.pc;
                        data_d  = fifo_rdata.target;
                    end
                end
                default: state_d = FLUSH;
            endcase
        end
    end

    always_ff @(posedge btbc_clk or negedge btbc_reset) begin
        if (!btbc_reset) begin
            state_q <= FLUSH;
            idx_q   <= '0;
            write_q <= 1'b0;
            inv_q   <= 1'b0;
            taken_q <= 1'b0;
            pc_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            inv_q   <= inv_d;
            taken_q <= taken_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
        end
    end

    assign bus.upd_ready        = ~fifo_full;
    assign bus.btb_write        = write_q;
    assign bus.btb_invalidate   = inv_q;
    assign bus.btb_branch_taken = taken_q;
    assign bus.btb_new_pc       = pc_q;
    assign bus.btb_data         = data_q;
    assign flush_busy           = (state_q == FLUSH);
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: queue-based reference model plus directed scenarios.
module tb_btb_update_ctrl;
  import btb_pkg::*;

  localparam int DEPTH = 4;
  localparam int IB    = 10;
  localparam int WALK  = 1 << IB;
  localparam int CW    = 3;
  localparam int VW    = 72;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_req = 1'b0;
  logic flush_busy;
  logic [CW-1:0] fifo_count;
  ctrl_state_e dbg_state;

  always #5 clk = ~clk;

  btb_update_ctrl_if bus ();

  btb_update_ctrl #(.DEPTH(DEPTH), .INDEX_BITS(IB), .INDEX_LSB(2)) dut (
    .btbc_clk   (clk),
    .btbc_reset (rst_n),
    .bus        (bus),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .fifo_count (fifo_count),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // reference model: pending updates as a queue, walk as a remaining index
  btb_upd_t    mdl_q[$];
  bit          mdl_flushing;
  int          mdl_idx;
  logic        e_write, e_inv, e_taken;
  logic [31:0] e_pc, e_data;
  btb_upd_t    mdl_in, mdl_out;
  bit          mdl_push;

  // scoreboard of expected RUN-mode writes {taken, target, pc}
  logic [64:0] exp_q[$];

  localparam logic [VW-1:0] RESET_VEC = {1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};

  task automatic model_reset();
    mdl_q.delete();
    mdl_flushing = 1'b1;
    mdl_idx = 0;
    e_write = 0; e_inv = 0; e_taken = 0; e_pc = '0; e_data = '0;
  endtask

  task automatic model_edge();
    mdl_push = bus.upd_valid && (mdl_q.size() < DEPTH);
    mdl_in = '{pc: bus.upd_pc, target: bus.upd_target, taken: bus.upd_taken};
    if (flush_req) begin
      mdl_q.delete();
      mdl_flushing = 1'b1;
      mdl_idx = 0;
      e_write = 0; e_inv = 0;
    end else begin
      if (mdl_flushing) begin
        e_write = 1; e_inv = 1; e_taken = 0; e_data = '0;
        e_pc = 32'(mdl_idx * 4);
        mdl_idx++;
        if (mdl_idx == WALK) mdl_flushing = 1'b0;
      end else if (mdl_q.size() > 0) begin
        mdl_out = mdl_q.pop_front();
        e_write = 1; e_inv = 0;
        e_taken = mdl_out.taken; e_pc = mdl_out.pc; e_data = mdl_out.target;
      end else begin
        e_write = 0; e_inv = 0;
      end
      if (mdl_push) mdl_q.push_back(mdl_in);
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {flush_busy, bus.upd_ready, fifo_count, bus.btb_write, bus.btb_invalidate,
            bus.btb_branch_taken, bus.btb_new_pc, bus.btb_data};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {mdl_flushing, (mdl_q.size() < DEPTH), CW'(mdl_q.size()), e_write, e_inv,
            e_taken, e_pc, e_data};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.upd_valid = 0; bus.upd_pc = '0; bus.upd_target = '0; bus.upd_taken = 0;
    flush_req = 0;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    bus.upd_valid = 1; bus.upd_pc = pc; bus.upd_target = tgt; bus.upd_taken = tk;
  endtask

  task automatic test_reset();
    drive_idle();
    model_reset();
    #12;
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", dut_vec(), RESET_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int busy_cycles = 0;
      for (int c = 0; c <= WALK + 2; c++) begin
        if (flush_busy === 1'b1) busy_cycles++;
        if (c > 0) begin
          checks++;
          if (dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL walk_after_reset cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec());
          end
          if (bus.btb_write && bus.btb_invalidate) begin
            checks++;
            if (bus.btb_new_pc !== 32'((c - 1) * 4)) begin
              failures++;
              $display("FAIL walk_pc_step cyc=%0d got=%h exp=%h", c, bus.btb_new_pc, 32'((c - 1) * 4));
            end
          end
        end
        if (c <= WALK + 1) tick();
      end
      checks++;
      if (busy_cycles != WALK) begin
        failures++;
        $display("FAIL flush_busy_len got=%0d exp=%0d", busy_cycles, WALK);
      end
      checks++;
      if (bus.btb_write !== 1'b0 || flush_busy !== 1'b0) begin
        failures++;
        $display("FAIL walk_end_idle got=%b%b exp=00", bus.btb_write, flush_busy);
      end
    end
  endtask

  task automatic test_single();
    drive_upd(32'h4, 32'hDEADBEEF, 1'b1);
    tick();
    drive_idle();
    checks++;
    if (bus.btb_write !== 1'b0 || fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL single_queued got=%b/%0d exp=0/1", bus.btb_write, fifo_count);
    end
    tick();
    checks++;
    if ({bus.btb_write, bus.btb_invalidate, bus.btb_branch_taken, bus.btb_new_pc, bus.btb_data}
        !== {3'b101, 32'h4, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL single_write got=%b%b%b %h %h exp=101 00000004 deadbeef", bus.btb_write,
               bus.btb_invalidate, bus.btb_branch_taken, bus.btb_new_pc, bus.btb_data);
    end
    tick();
    checks++;
    if (bus.btb_write !== 1'b0 || bus.btb_data !== 32'hDEADBEEF || bus.btb_new_pc !== 32'h4) begin
      failures++;
      $display("FAIL single_one_cycle got=%b %h %h exp=0 00000004 deadbeef",
               bus.btb_write, bus.btb_new_pc, bus.btb_data);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      failures++;
      $display("FAIL single_model got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_full();
    logic [31:0] pcs [5];
    int first_c, last_c, nwr;
    pcs = '{32'h1004, 32'h1000, 32'h1008, 32'h100C, 32'h1010};
    flush_req = 1;
    tick();
    flush_req = 0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      drive_upd(pcs[i], 32'hB000_0000 + 32'(i), i[0]);
      tick();
      if (i < 4) exp_q.push_back({i[0], 32'hB000_0000 + 32'(i), pcs[i]});
      if (i >= 3) begin
        checks++;
        if (bus.upd_ready !== 1'b0 || fifo_count !== 3'd4) begin
          failures++;
          $display("FAIL full_hold push=%0d got=%b/%0d exp=0/4", i, bus.upd_ready, fifo_count);
        end
      end
    end
    drive_idle();
    first_c = -1; last_c = -1; nwr = 0;
    for (int c = 0; c < WALK + 20; c++) begin
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL full_model cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
      if (bus.btb_write && !bus.btb_invalidate) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        nwr++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL full_extra_write got=%h exp=none", bus.btb_new_pc);
        end else if ({bus.btb_branch_taken, bus.btb_data, bus.btb_new_pc} !== exp_q[0]) begin
          failures++;
          $display("FAIL full_order got=%h exp=%h",
                   {bus.btb_branch_taken, bus.btb_data, bus.btb_new_pc}, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
    checks++;
    if (nwr != 4 || exp_q.size() != 0 || last_c - first_c != 3) begin
      failures++;
      $display("FAIL full_drain got=%0d writes span=%0d exp=4 writes span=3", nwr, last_c - first_c);
    end
  endtask

  task automatic test_back_to_back();
    int nwr = 0;
    exp_q.delete();
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        logic [31:0] tgt;
        logic tk;
        tgt = $urandom;
        tk = (c == 3);
        drive_upd(32'h4, tgt, tk);
        exp_q.push_back({tk, tgt, 32'h4});
      end else begin
        drive_idle();
      end
      tick();
      checks++;
      if (fifo_count > 3'd1) begin
        failures++;
        $display("FAIL b2b_count cyc=%0d got=%0d exp<=1", c, fifo_count);
      end
      if (bus.btb_write) begin
        nwr++;
        checks++;
        if (exp_q.size() == 0 || {bus.btb_branch_taken, bus.btb_data, bus.btb_new_pc} !== exp_q[0]) begin
          failures++;
          $display("FAIL b2b_order cyc=%0d got=%h", c, {bus.btb_branch_taken, bus.btb_data, bus.btb_new_pc});
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        checks++;
        if (nwr != c) begin
          failures++;
          $display("FAIL b2b_consecutive got=cyc%0d exp=cyc%0d", c, nwr);
        end
      end
    end
    checks++;
    if (nwr != 4) begin
      failures++;
      $display("FAIL b2b_total got=%0d exp=4", nwr);
    end
  endtask

  task automatic test_flush_discard();
    int leaked = 0;
    flush_req = 1;
    tick();
    flush_req = 0;
    drive_upd(32'hA000_0000, 32'h1, 1'b1);
    tick();
    drive_upd(32'hA000_0004, 32'h2, 1'b0);
    tick();
    checks++;
    if (fifo_count !== 3'd2) begin
      failures++;
      $display("FAIL discard_queued got=%0d exp=2", fifo_count);
    end
    drive_upd(32'hA000_0008, 32'h3, 1'b1);
    flush_req = 1;
    tick();
    drive_idle();
    checks++;
    if (fifo_count !== 3'd0 || flush_busy !== 1'b1) begin
      failures++;
      $display("FAIL discard_cleared got=%0d/%b exp=0/1", fifo_count, flush_busy);
    end
    tick();
    checks++;
    if ({bus.btb_write, bus.btb_invalidate, bus.btb_new_pc} !== {2'b11, 32'h0}) begin
      failures++;
      $display("FAIL discard_walk_restart got=%b%b %h exp=11 00000000",
               bus.btb_write, bus.btb_invalidate, bus.btb_new_pc);
    end
    for (int c = 0; c < WALK + 10; c++) begin
      tick();
      if (bus.btb_write && !bus.btb_invalidate) leaked++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL discard_model cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
    end
    checks++;
    if (leaked != 0) begin
      failures++;
      $display("FAIL discard_leak got=%0d writes exp=0", leaked);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    flush_req = 1;
    tick();
    flush_req = 0;
    drive_upd(32'hC000_0000, 32'h11, 1'b1);
    tick();
    drive_upd(32'hC000_0004, 32'h22, 1'b1);
    tick();
    drive_idle();
    while (bus.btb_new_pc !== 32'h554 && guard < WALK) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= WALK || fifo_count !== 3'd2) begin
      failures++;
      $display("FAIL midreset_reach got=%h/%0d exp=00000554/2", bus.btb_new_pc, fifo_count);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL midreset_async got=%h exp=%h", dut_vec(), RESET_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bus.btb_write, bus.btb_invalidate, bus.btb_new_pc, fifo_count} !== {2'b11, 32'h0, 3'd0}) begin
      failures++;
      $display("FAIL midreset_restart got=%b%b %h %0d exp=11 00000000 0",
               bus.btb_write, bus.btb_invalidate, bus.btb_new_pc, fifo_count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2600; c++) begin
      if ($urandom_range(0, 99) < 60)
        drive_upd({$urandom_range(0, 255), 2'b00} | 32'h8000_0000, $urandom, 1'($urandom_range(0, 1)));
      else
        bus.upd_valid = 0;
      flush_req = (c == 1400);
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_flush_discard();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
